timer_count_ctrl: RTL and testbench

Sequencing core for the 8-bit APB timer: consumes the control and update-data registers held by the APB register block and drives the counter, prescaler, and overflow/underflow flags. Sits between the APB register block (configuration, status clear) and any interrupt or readback logic. Everything runs on PCLK; the counter advances only on prescaled ticks.

---
 rtl/timer_count_ctrl_pkg.sv | 20 ++
 rtl/timer_count_ctrl_if.sv | 26 ++
 rtl/timer_count_ctrl_prescaler.sv | 27 ++
 rtl/timer_count_ctrl.sv | 87 ++++++++
 tb/tb_timer_count_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_count_ctrl_pkg.sv
// timer_pkg: shared types and constants for the 8-bit APB timer sequencing core.
//   Contents: FSM state enum (2-bit), control-register bit indices,
//   prescaler clock-select encodings, counter maximum and the tick mask helper.
//   Optional feature macro used by the core: TMR_ONESHOT_EN.
package timer_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int DIV_W_DEF = 4;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
    localparam int CTRL_LOAD    = 7;
    localparam int CTRL_OS      = 6;
    localparam int CTRL_DOWN    = 5;
    localparam int CTRL_EN      = 4;
    localparam int CTRL_CKS_LSB = 0;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_e;
    typedef enum logic [1:0] {CKS_DIV2, CKS_DIV4, CKS_DIV8, CKS_DIV16} cks_e;
    // Low (cks+1) bits set: the prescaler ticks when all of them are ones.
    function automatic logic [DIV_W_DEF-1:0] cks_mask(input cks_e cks);
        return DIV_W_DEF'((5'd2 << cks) - 5'd1);
    endfunction
endpackage

// File: rtl/timer_count_ctrl_if.sv
// timer_count_ctrl_if: register-block <-> timer core signal bundle.
//   master (APB register block): drives ctrl_reg, tdr, ovf_clr, udf_clr;
//                                observes tcnt, tmr_ovf, tmr_udf, load_done.
//   slave  (timer_count_ctrl):   the mirror image.
interface timer_count_ctrl_if
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic [7:0]       ctrl_reg;
    logic [CNT_W-1:0] tdr;
    logic             ovf_clr;
    logic             udf_clr;
    logic [CNT_W-1:0] tcnt;
    logic             tmr_ovf;
    logic             tmr_udf;
    logic             load_done;
    modport master (
        output ctrl_reg, tdr, ovf_clr, udf_clr,
        input  tcnt, tmr_ovf, tmr_udf, load_done
    );
    modport slave (
        input  ctrl_reg, tdr, ovf_clr, udf_clr,
        output tcnt, tmr_ovf, tmr_udf, load_done
    );
endinterface

// File: rtl/timer_count_ctrl_prescaler.sv
// timer_prescaler: free-running PCLK divider producing the counter tick.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   clear         : zero the prescaler (wins over run)
//   run           : advance the prescaler every PCLK
//   cks           : divide select, 2/4/8/16
//   tick          : high in the cycle the low (cks+1) bits are all ones
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic run,
    input  cks_e cks,
    output logic tick
);
    logic [DIV_W-1:0] presc_q, presc_d, mask;
    assign mask    = DIV_W'(cks_mask(cks));
    assign presc_d = clear ? '0 : run ? presc_q + DIV_W'(1) : presc_q;
    assign tick    = run && ((presc_q & mask) == mask);
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) presc_q <= '0;
        else          presc_q <= presc_d;
    end
endmodule

// File: rtl/timer_count_ctrl.sv
// timer_count_ctrl: sequencing core of the 8-bit APB timer (FSM, counter, sticky flags).
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   bus (slave)   : ctrl_reg {load, one-shot, down, en, rsvd[1:0], cks[1:0]}, tdr,
//                   ovf_clr/udf_clr in; tcnt, tmr_ovf, tmr_udf, load_done out
//   Optional macro TMR_ONESHOT_EN: ctrl_reg[6] stops the counter in STOP after a wrap.
module timer_count_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input logic               PCLK,
    input logic               PRESETn,
    timer_count_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             load_q, load_d;
    logic             en, down, load_edge, run, tick, adv, wrap, stop_hit;
    cks_e             cks;
    assign en        = bus.ctrl_reg[CTRL_EN];
    assign down      = bus.ctrl_reg[CTRL_DOWN];
    assign cks       = cks_e'(bus.ctrl_reg[CTRL_CKS_LSB +: 2]);
    assign load_d    = bus.ctrl_reg[CTRL_LOAD];
    assign load_edge = load_d && !load_q;
    assign run       = state_q == RUN;
    // A tick only counts if RUN is kept this cycle: load edge and en drop both win.
    assign adv       = run && tick && en && !load_edge;
    assign wrap      = down ? cnt_q == '0 : cnt_q == {CNT_W{1'b1}};
`ifdef TMR_ONESHOT_EN
    assign stop_hit  = adv && wrap && bus.ctrl_reg[CTRL_OS];
    logic unused_ok;
    assign unused_ok = ^bus.ctrl_reg[3:2];
`else
    assign stop_hit  = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{bus.ctrl_reg[3:2], bus.ctrl_reg[CTRL_OS]};
`endif
    timer_prescaler #(.DIV_W(DIV_W)) u_presc (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (!run),
        .run     (run),
        .cks     (cks),
        .tick    (tick)
    );
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            load_q  <= load_d;
        end
    end
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = load_edge ? LOAD : en ? RUN : IDLE;
            LOAD:    state_d = en ? RUN : IDLE;
            RUN:     state_d = load_edge ? LOAD : !en ? IDLE : stop_hit ? STOP : RUN;
`ifdef TMR_ONESHOT_EN
            STOP:    state_d = load_edge ? LOAD : en ? STOP : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end
    // Counter and flags; a set coinciding with its clear leaves the flag set.
    always_comb begin
        cnt_d = state_q == LOAD ? bus.tdr
              : adv ? (down ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1))
              : cnt_q;
        ovf_d = (adv && !down && wrap) || (ovf_q && !bus.ovf_clr);
        udf_d = (adv && down && wrap) || (udf_q && !bus.udf_clr);
    end
    assign bus.tcnt      = cnt_q;
    assign bus.tmr_ovf   = ovf_q;
    assign bus.tmr_udf   = udf_q;
    assign bus.load_done = state_q == LOAD;
endmodule

// File: tb/tb_timer_count_ctrl.sv
// tb_timer_count_ctrl: directed test-plan sequences plus random stimulus against a spec-level model.
module tb_timer_count_ctrl;
    import timer_pkg::*;
    logic PCLK = 1'b0;
    logic PRESETn = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    timer_count_ctrl_if #(.CNT_W(8)) bus ();
    timer_count_ctrl #(.CNT_W(8), .DIV_W(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );
    always #5 PCLK = ~PCLK;
`ifdef TMR_ONESHOT_EN
    localparam bit OS_BUILT = 1'b1;
`else
    localparam bit OS_BUILT = 1'b0;
`endif
    int m_cnt, m_pre;
    bit m_ovf, m_udf, m_prev7, m_run, m_load, m_stop;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_ovf = 0; m_udf = 0;
        m_prev7 = 0; m_run = 0; m_load = 0; m_stop = 0;
    endtask
    // Advance the model by one PCLK using the inputs currently applied.
    task automatic model_step();
        bit [7:0] c = bus.ctrl_reg;
        bit ld  = c[7] && !m_prev7;
        bit en  = c[4];
        bit dn  = c[5];
        bit os  = OS_BUILT && c[6];
        int div = 2 << c[1:0];
        bit so = 0, su = 0;
        if (m_load) begin
            m_cnt = bus.tdr; m_pre = 0; m_load = 0; m_run = en;
        end else if (ld) begin
            m_load = 1; m_run = 0; m_stop = 0;
        end else if (m_run) begin
            if (!en) begin
                m_run = 0; m_pre = 0;
            end else begin
                if ((m_pre + 1) % div == 0) begin
                    if (dn) begin su = m_cnt == 0;   m_cnt = (m_cnt + 255) % 256; end
                    else    begin so = m_cnt == 255; m_cnt = (m_cnt + 1) % 256; end
                    if ((so || su) && os) begin m_run = 0; m_stop = 1; end
                end
                m_pre = (m_pre + 1) % 16;
            end
        end else if (m_stop) begin
            if (!en) m_stop = 0;
        end else if (en) begin
            m_run = 1; m_pre = 0;
        end
        m_ovf = so || (m_ovf && !bus.ovf_clr);
        m_udf = su || (m_udf && !bus.udf_clr);
        m_prev7 = c[7];
    endtask
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge PCLK);
            #1;
            chk("tcnt", bus.tcnt, m_cnt);
            chk("tmr_ovf", bus.tmr_ovf, m_ovf);
            chk("tmr_udf", bus.tmr_udf, m_udf);
            chk("load_done", bus.load_done, m_load);
        end
    endtask
    // Reset asserted off the clock grid; outputs must clear before any edge.
    task automatic async_reset();
        #($urandom_range(2, 7));
        PRESETn = 1'b0;
        #1;
        chk("rst_tcnt", bus.tcnt, 0);
        chk("rst_ovf", bus.tmr_ovf, 0);
        chk("rst_udf", bus.tmr_udf, 0);
        chk("rst_load_done", bus.load_done, 0);
        @(posedge PCLK);
        #3;
        PRESETn = 1'b1;
        model_reset();
    endtask
    task automatic do_load(input logic [7:0] v);
        bus.ctrl_reg = 8'h00;
        cyc(1);
        bus.tdr = v;
        bus.ctrl_reg = 8'h80;
        cyc(2);
    endtask
    initial begin
        bus.ctrl_reg = 8'h00;
        bus.tdr = 8'h00;
        bus.ovf_clr = 1'b0;
        bus.udf_clr = 1'b0;
        #2;
        PRESETn = 1'b0;
        #1;
        chk("reset_tcnt", bus.tcnt, 0);
        chk("reset_ovf", bus.tmr_ovf, 0);
        chk("reset_udf", bus.tmr_udf, 0);
        chk("reset_load_done", bus.load_done, 0);
        repeat (2) @(posedge PCLK);
        #3;
        PRESETn = 1'b1;
        model_reset();
        // load while idle
        cyc(2);
        bus.tdr = 8'h3C;
        bus.ctrl_reg = 8'h80;
        cyc(1);
        chk("load_pulse", bus.load_done, 1);
        cyc(1);
        chk("load_value", bus.tcnt, 8'h3C);
        chk("load_pulse_end", bus.load_done, 0);
        cyc(20);
        chk("load_hold", bus.tcnt, 8'h3C);
        // up overflow at divide-by-2
        do_load(8'hFD);
        bus.ctrl_reg = 8'h10;
        cyc(3);
        chk("up_fe", bus.tcnt, 8'hFE);
        cyc(2);
        chk("up_ff", bus.tcnt, 8'hFF);
        cyc(2);
        chk("up_wrap", bus.tcnt, 8'h00);
        chk("ovf_set", bus.tmr_ovf, 1);
        bus.ovf_clr = 1'b1;
        cyc(1);
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", bus.tmr_ovf, 0);
        // down underflow at divide-by-16
        do_load(8'h01);
        bus.ctrl_reg = 8'h33;
        cyc(17);
        chk("down_00", bus.tcnt, 8'h00);
        chk("down_no_udf", bus.tmr_udf, 0);
        cyc(16);
        chk("down_wrap", bus.tcnt, 8'hFF);
        chk("udf_set", bus.tmr_udf, 1);
        chk("udf_no_ovf", bus.tmr_ovf, 0);
        // clear coinciding with a wrap keeps the flag
        do_load(8'hFE);
        bus.ctrl_reg = 8'h10;
        cyc(4);
        bus.ovf_clr = 1'b1;
        cyc(1);
        bus.ovf_clr = 1'b0;
        chk("collide_cnt", bus.tcnt, 8'h00);
        chk("collide_ovf", bus.tmr_ovf, 1);
        // load edge on a tick cycle drops the tick
        cyc(1);
        bus.tdr = 8'h5A;
        bus.ctrl_reg = 8'h90;
        cyc(1);
        chk("prio_no_inc", bus.tcnt, 8'h00);
        chk("prio_pulse", bus.load_done, 1);
        cyc(1);
        chk("prio_value", bus.tcnt, 8'h5A);
        bus.ctrl_reg = 8'h10;
        // enable drop holds the count
        do_load(8'h42);
        bus.ctrl_reg = 8'h10;
        cyc(1);
        bus.ctrl_reg = 8'h00;
        cyc(10);
        chk("en_drop_hold", bus.tcnt, 8'h42);
        bus.ctrl_reg = 8'h10;
        cyc(3);
        chk("en_resume", bus.tcnt, 8'h43);
        cyc(5);
        async_reset();
        cyc(4);
`ifdef TMR_ONESHOT_EN
        do_load(8'hFE);
        bus.ctrl_reg = 8'h50;
        cyc(3);
        chk("os_ff", bus.tcnt, 8'hFF);
        cyc(2);
        chk("os_wrap", bus.tcnt, 8'h00);
        chk("os_ovf", bus.tmr_ovf, 1);
        cyc(10);
        chk("os_stop_hold", bus.tcnt, 8'h00);
        bus.ctrl_reg = 8'h40;
        cyc(2);
        bus.ctrl_reg = 8'h50;
        cyc(3);
        chk("os_resume", bus.tcnt, 8'h01);
`endif
        // random traffic, live cks/down changes, clears and one mid-run reset
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(15) == 0) begin
                bus.ctrl_reg = 8'($urandom);
                if ($urandom_range(3) != 0) bus.ctrl_reg[4] = 1'b1;
            end
            bus.tdr = 8'($urandom);
            bus.ovf_clr = $urandom_range(7) == 0;
            bus.udf_clr = $urandom_range(7) == 0;
            cyc(1);
            if (i == 1200) begin
                bus.ctrl_reg[7] = 1'b0;
                async_reset();
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
